muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide operations. It accepts one M-extension operation from the execute stage and holds the pipeline stalled while the operation runs. Multiplies complete in one registered cycle; divides and remainders run a 32-iteration restoring divider. It returns a single-cycle `done` pulse with the 32-bit result, and sits beside the base ALU, selected when the decoded operation is an M-extension op.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  funct3 of the M-op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `a`, `b`  in  32 each  rs1, rs2 operands; sampled with `start`.
- `flush`  in  1  abort the current operation.
- `busy`  out  1  high in any state other than IDLE.
- `stall`  out  1  `(start & IDLE) | (busy & ~done)`; holds the pipeline.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  32  registered result; holds its value until the next load.

## Operation
- States:
  - IDLE: `start` → MUL if `op[2]`=0; FIX_EARLY if special div case; else DIV.
  - MUL → DONE.
  - DIV (32 cycles, `cnt` 0..31) → FIX at `cnt`=31.
  - FIX → DONE.
  - FIX_EARLY → DONE.
  - DONE → IDLE.
- Operand capture on accept: `op`, `a`, `b` are latched. Later changes on the inputs have no effect.
- MUL: form the 64-bit product with operand signedness per op:
  - mul: low 32 bits.
  - mulh: signed×signed, high 32 bits.
  - mulhsu: signed `a` × unsigned `b`, high 32 bits.
  - mulhu: unsigned×unsigned, high 32 bits.
  - The product is registered into `result` at the end of MUL.
- DIV/REM (signed): divide the magnitudes `|a|`, `|b|`.
  - FIX negates the quotient if `sign(a)≠sign(b)`.
  - FIX negates the remainder if `a` is negative.
- Unsigned divide: no negation; FIX passes the value through.
- Special cases, detected at accept and resolved in FIX_EARLY without iterating:
  - `b`=0: div/divu → 0xFFFFFFFF; rem/remu → `a`.
  - Signed overflow, `a`=0x80000000 and `b`=0xFFFFFFFF: div → 0x80000000; rem → 0.
- Divider step, each DIV cycle: `{rem,quo} <<= 1`; if `rem ≥ divisor`, then `rem -= divisor` and `quo[0]=1`. Use a 33-bit subtract for the compare.
- `start` while busy (including the DONE cycle) is ignored; no queueing.
- `flush`:
  - In any state other than IDLE: the next state is IDLE, no `done` is issued, and `result` is unchanged.
  - `flush` and `start` together in IDLE: `flush` wins; the op is not accepted.
- `rst` has priority over everything.

## Timing
- Reset values: state IDLE, `busy`=0, `stall`=0, `done`=0, `result`=0, `cnt`=0.
- Accept edge = cycle 0. `done` is asserted in:
  - Multiply: cycle 2.
  - Divide/remainder: cycle 34.
  - Special case: cycle 2.
- `busy` rises in cycle 1 and falls in the cycle after DONE.
- `stall` is high in cycle 0 (combinational from `start`) through the cycle before `done`. It is low in the DONE cycle, so the pipeline captures `result` and advances.
- Reset mid-division: the next cycle is IDLE with all outputs at their reset values; the partial result is discarded.
- Back-to-back operations: the earliest next accept is the cycle after DONE, i.e. cycle 3 for a multiply and cycle 35 for a divide.

## Structure
- Package `mdu_pkg`: the op encodings (`MDU_MUL` … `MDU_REMU`), the state enum, `XLEN`, and the overflow constants 0x80000000 and 0xFFFFFFFF.
- Sub-module `div_step`: a combinational one-iteration restoring step (inputs `rem`, `quo`, `divisor`; outputs the next `rem` and `quo`). The sequencer instantiates it once and iterates over it.
- The top level holds the FSM, the counter, the operand and sign registers, the multiplier, and the result register.

## Test plan
- mul `a`=7, `b`=0xFFFFFFFD (−3) → `done` in cycle 2, `result`=0xFFFFFFEB; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF×2 → 0xFFFFFFFF.
- div `a`=0xFFFFFFF9 (−7), `b`=2 → `done` in cycle 34, `result`=0xFFFFFFFD; rem with the same operands → 0xFFFFFFFF; divu 100/7 → 14, remu → 2.
- divu 5/0 → 0xFFFFFFFF and remu 5/0 → 5, each with `done` in cycle 2; div 0x80000000/0xFFFFFFFF → 0x80000000, rem → 0.
- `start` held high continuously: each op is accepted only in IDLE and produces exactly one `done` pulse per accepted op; operand changes during DIV do not alter `result`.
- `flush` at cycle 10 of a div → IDLE next cycle, no `done`, `result` unchanged; `flush` and `start` together in IDLE → no accept.
- `rst` at cycle 20 of a div → all outputs at reset values next cycle; a following mul 3×4 → 12.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   - mdu_op_e    : funct3 encodings of the M-extension operations
//   - mdu_state_e : sequencer FSM states
//   - XLEN        : operand/result width (only 32 is supported)
//   - OVF_DIVIDEND / OVF_DIVISOR : operands of the one signed-divide overflow case
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_FIX_EARLY,
    ST_DONE
  } mdu_state_e;

  localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the execute stage and the
// multiply/divide sequencer.
//   start  : request, only taken while the sequencer is idle
//   op     : funct3 of the M-op
//   a, b   : rs1 / rs2 operands, captured with start
//   flush  : abort the operation in flight
//   busy   : sequencer is not idle
//   stall  : hold the pipeline
//   done   : one-cycle completion pulse, result valid alongside it
//   result : registered result
interface muldiv_seq_if;
  import mdu_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, result
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational iteration of a restoring divider.
//   i_rem, i_quo : partial remainder and quotient/dividend shift register
//   i_divisor    : divisor magnitude
//   o_rem, o_quo : values after one shift-and-conditional-subtract step
module div_step
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  assign w_shifted = {i_rem, i_quo[XLEN-1]};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  // i_rem < i_divisor always holds, so w_shifted < 2*divisor: when the
  // subtract succeeds the difference is below 2^32, and when it borrows the
  // wrapped value is at least 2^32. Bit XLEN is therefore a clean borrow flag.
  assign w_ge      = ~w_diff[XLEN];

  assign o_rem = w_ge ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M sequencer. Multiplies finish in one registered
// cycle; div/rem run 32 iterations of div_step followed by a sign fix-up;
// divide-by-zero and signed overflow resolve immediately in FIX_EARLY.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : muldiv_seq_if.slave (start/op/a/b/flush in, busy/stall/done/result out)
module muldiv_seq
  import mdu_pkg::*;
(
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  mdu_state_e      r_state;
  mdu_state_e      w_next_state;
  logic [4:0]      r_cnt;
  mdu_op_e         r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_result;
  logic            r_neg_q;
  logic            r_neg_r;

  // ---------------------------------------------------------------- accept
  logic            w_idle;
  logic            w_accept;
  logic            w_in_signed;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle & bus.start & ~bus.flush;
  // div (100) and rem (110) are the signed divide ops
  assign w_in_signed = bus.op[2] & ~bus.op[0];
  assign w_div_zero  = (bus.b == '0);
  assign w_ovf       = w_in_signed & (bus.a == OVF_DIVIDEND) & (bus.b == OVF_DIVISOR);
  assign w_special   = bus.op[2] & (w_div_zero | w_ovf);
  assign w_abs_a     = (w_in_signed & bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign w_abs_b     = (w_in_signed & bus.b[XLEN-1]) ? -bus.b : bus.b;

  // ------------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves the signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (w_accept) w_next_state = !bus.op[2] ? ST_MUL
                                               : (w_special ? ST_FIX_EARLY : ST_DIV);
      ST_MUL:       w_next_state = ST_DONE;
      ST_DIV:       if (r_cnt == 5'd31) w_next_state = ST_FIX;
      ST_FIX:       w_next_state = ST_DONE;
      ST_FIX_EARLY: w_next_state = ST_DONE;
      ST_DONE:      w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
    if (bus.flush) w_next_state = ST_IDLE;
  end

  logic w_busy;
  logic w_done;

  always_comb begin
    w_busy = ~w_idle;
    w_done = (r_state == ST_DONE);
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.stall  = (bus.start & w_idle) | (w_busy & ~w_done);
  assign bus.result = r_result;

  // --------------------------------------------------------------- divider
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // NOTE: operand and divider registers carry no reset: they are always
  // loaded on accept before anything reads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op      <= mdu_op_e'(bus.op);
      r_a       <= bus.a;
      r_b       <= bus.b;
      r_rem     <= '0;
      r_quo     <= w_abs_a;
      r_divisor <= w_abs_b;
      r_neg_q   <= w_in_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
      r_neg_r   <= w_in_signed & bus.a[XLEN-1];
    end else if (r_state == ST_DIV) begin
      r_rem <= w_step_rem;
      r_quo <= w_step_quo;
    end
  end

  // ------------------------------------------------------------ multiplier
  // Operands are extended to 64 bits with per-op signedness; the low 64 bits
  // of the product are then correct for every signed/unsigned mix.
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_a_sgn   = (r_op == MDU_MULH) | (r_op == MDU_MULHSU);
  assign w_b_sgn   = (r_op == MDU_MULH);
  assign w_a_ext   = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
  assign w_b_ext   = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (r_op == MDU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // ---------------------------------------------------------- result fix-up
  logic [XLEN-1:0] w_quo_fixed;
  logic [XLEN-1:0] w_rem_fixed;
  logic [XLEN-1:0] w_fix_res;
  logic [XLEN-1:0] w_early_res;

  assign w_quo_fixed = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fixed = r_neg_r ? -r_rem : r_rem;
  // op[1] separates rem/remu from div/divu
  assign w_fix_res   = r_op[1] ? w_rem_fixed : w_quo_fixed;
  // Only two special cases reach FIX_EARLY: divide by zero, else signed overflow.
  assign w_early_res = (r_b == '0) ? (r_op[1] ? r_a : '1)
                                   : (r_op[1] ? '0  : OVF_DIVIDEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept)                r_cnt <= '0;
      else if (r_state == ST_DIV)  r_cnt <= r_cnt + 5'd1;

      if (!bus.flush) begin
        case (r_state)
          ST_MUL:       r_result <= w_mul_res;
          ST_FIX:       r_result <= w_fix_res;
          ST_FIX_EARLY: r_result <= w_early_res;
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq. The driver issues one input
// set per cycle and, from a cycle-level model of when the sequencer is idle,
// pushes the expected result and done cycle on each accept. A monitor on the
// falling edge checks busy/stall/done every cycle, pops an entry on each done
// pulse, and checks that result holds between completions.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          m_acc = -100;   // cycle of the last accept
  int          m_free = 0;     // first cycle in which the sequencer is idle again
  logic [31:0] m_last_result = '0;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference results straight from the RV32M rules.
  function automatic logic [31:0] ref_model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      ux = longint'({32'b0, x});
    longint      uy = longint'({32'b0, y});
    logic [63:0] p;
    bit          ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'b000: begin p = ux * uy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (ovf)    return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    if (!o[2]) return 2;
    if (y == 0) return 2;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // One cycle of stimulus; model bookkeeping for accept and flush.
  task automatic tick(bit s, bit f, bit r, logic [2:0] o, logic [31:0] x, logic [31:0] y,
                      bit use_exp, logic [31:0] exp_v);
    exp_t e;
    int   lat;
    @(posedge clk);
    #1;
    bus.start = s; bus.flush = f; rst = r;
    bus.op = o; bus.a = x; bus.b = y;
    if (!r) begin
      if (f) begin
        if (cyc > m_acc && cyc < m_free) begin
          if (sb_q.size() > 0 && sb_q[$].done_cyc > cyc) void'(sb_q.pop_back());
          m_free = cyc + 1;
        end
      end else if (s && cyc >= m_free) begin
        lat        = latency(o, x, y);
        e.res      = use_exp ? exp_v : ref_model(o, x, y);
        e.done_cyc = cyc + lat;
        sb_q.push_back(e);
        m_acc  = cyc;
        m_free = cyc + lat + 1;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 80) begin
      idle(1);
      n++;
    end
    check("drain timeout", sb_q.size(), 0);
  endtask

  task automatic run_op(logic [2:0] o, logic [31:0] x, logic [31:0] y,
                        bit use_exp, logic [31:0] exp_v);
    tick(1'b1, 1'b0, 1'b0, o, x, y, use_exp, exp_v);
    drain();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: protocol checks every cycle, scoreboard pop on done.
  always @(negedge clk) begin : monitor
    bit   exp_busy;
    bit   exp_done;
    exp_t e;
    if (mon_en) begin
      exp_busy = (cyc > m_acc) && (cyc < m_free);
      exp_done = exp_busy && sb_q.size() > 0 && sb_q[0].done_cyc == cyc;
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("done", 32'(bus.done), 32'(exp_done));
      check("stall", 32'(bus.stall), 32'((bus.start && !exp_busy) || (exp_busy && !exp_done)));
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected done", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("done cycle", 32'(cyc), 32'(e.done_cyc));
          check("result", bus.result, e.res);
          m_last_result = e.res;
        end
      end else begin
        check("result hold", bus.result, m_last_result);
      end
      if (rst) begin
        sb_q.delete();
        m_free        = cyc + 1;
        m_last_result = '0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    idle(1);

    // Directed values with hand-computed results.
    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
    run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         1'b1, 32'hFFFF_FFFF);
    run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd100,        32'd7,         1'b1, 32'd14);
    run_op(3'b111, 32'd100,        32'd7,         1'b1, 32'd2);
    run_op(3'b101, 32'd5,          32'd0,         1'b1, 32'hFFFF_FFFF);
    run_op(3'b111, 32'd5,          32'd0,         1'b1, 32'd5);
    run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'd0);

    // start held high with operands changing every cycle.
    for (int i = 0; i < 400; i++)
      tick(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'b0, 32'd0);
    drain();

    // flush at cycle 10 of a divide, then flush+start together in IDLE.
    tick(1'b1, 1'b0, 1'b0, 3'b101, 32'd1000, 32'd3, 1'b0, 32'd0);
    idle(9);
    tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    idle(5);
    tick(1'b1, 1'b1, 1'b0, 3'b000, 32'd9, 32'd9, 1'b0, 32'd0);
    idle(3);

    // reset at cycle 20 of a divide, then a multiply.
    tick(1'b1, 1'b0, 1'b0, 3'b100, 32'hDEAD_BEEF, 32'd17, 1'b0, 32'd0);
    idle(19);
    tick(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    run_op(3'b000, 32'd3, 32'd4, 1'b1, 32'd12);

    // Random single operations with random flush points.
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(0, 20));
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      end
      drain();
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
